// File: rtl/snake_cell.sv
// One LED-matrix snake playfield cell: tracks head/body/apple/collision occupancy
// and counts down the body segment so the cell stays lit for exactly `length` ticks.
module snake_cell #(
  parameter int LEN_W     = 8,
  parameter bit INIT_HEAD = 1'b0,
  parameter int INIT_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             head_from_l,
  input  logic             head_from_u,
  input  logic             head_from_r,
  input  logic             head_from_d,
  input  logic [1:0]       dir,
  input  logic [LEN_W-1:0] length,
  input  logic             apple_place,
  output logic             lit,
  output logic             head,
  output logic             apple,
  output logic             collision,
  output logic             ate
);

  typedef enum logic [2:0] {S_OFF, S_HEAD, S_BODY, S_APPLE, S_COLL} state_t;

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] RST_CNT = INIT_HEAD ? LEN_W'(INIT_LEN) : '0;

  state_t           state, state_n;
  logic [LEN_W-1:0] count, count_n, load_len;
  logic             sel_head, entry, ate_n;

  // The head moves in direction dir, so it arrives from the opposite neighbour.
  always_comb begin
    case (dir)
      2'b00:   sel_head = head_from_r;
      2'b01:   sel_head = head_from_d;
      2'b10:   sel_head = head_from_l;
      default: sel_head = head_from_u;
    endcase
  end

  assign entry    = tick & sel_head;
  assign load_len = (length == '0) ? ONE : length;

  always_comb begin
    state_n = state;
    count_n = count;
    ate_n   = 1'b0;
    if (clear) begin
      state_n = S_OFF;
      count_n = '0;
    end else if (entry) begin
      case (state)
        S_OFF: begin
          state_n = S_HEAD;
          count_n = load_len;
        end
        S_APPLE: begin
          state_n = S_HEAD;
          count_n = load_len;
          ate_n   = 1'b1;
        end
        S_BODY: begin
          // Last body segment vacates on the same tick the head arrives.
          if (count == ONE) begin
            state_n = S_HEAD;
            count_n = load_len;
          end else begin
            state_n = S_COLL;
            count_n = '0;
          end
        end
        S_HEAD: begin
          state_n = S_COLL;
          count_n = '0;
        end
        default: state_n = S_COLL;
      endcase
    end else if (tick && (state == S_HEAD || state == S_BODY)) begin
      if (count <= ONE) begin
        state_n = S_OFF;
        count_n = '0;
      end else begin
        state_n = S_BODY;
        count_n = count - ONE;
      end
    end else if (apple_place && state == S_OFF) begin
      state_n = S_APPLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT_HEAD ? S_HEAD : S_OFF;
      count     <= RST_CNT;
      lit       <= INIT_HEAD;
      head      <= INIT_HEAD;
      apple     <= 1'b0;
      collision <= 1'b0;
      ate       <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      lit       <= (state_n == S_HEAD) || (state_n == S_BODY) || (state_n == S_COLL);
      head      <= (state_n == S_HEAD);
      apple     <= (state_n == S_APPLE);
      collision <= (state_n == S_COLL);
      ate       <= ate_n;
    end
  end

endmodule

// File: tb/tb_snake_cell.sv
// Bench for snake_cell: scripted steps push expected {lit,head,apple,collision,ate}
// into a scoreboard that is popped and compared after each clock edge.
module tb_snake_cell;

  localparam int LEN_W = 8;

  logic             clk, reset;
  logic             tick, clear, hl, hu, hr, hd, apple_place;
  logic [1:0]       dir;
  logic [LEN_W-1:0] length;
  logic             lit, head, apple, collision, ate;
  logic             tick_h;
  logic             lit_h, head_h, apple_h, collision_h, ate_h;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];
  logic [4:0] o, o_h;
  assign o   = {lit, head, apple, collision, ate};
  assign o_h = {lit_h, head_h, apple_h, collision_h, ate_h};

  snake_cell #(.LEN_W(LEN_W), .INIT_HEAD(1'b0), .INIT_LEN(3)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear),
    .head_from_l(hl), .head_from_u(hu), .head_from_r(hr), .head_from_d(hd),
    .dir(dir), .length(length), .apple_place(apple_place),
    .lit(lit), .head(head), .apple(apple), .collision(collision), .ate(ate)
  );

  snake_cell #(.LEN_W(LEN_W), .INIT_HEAD(1'b1), .INIT_LEN(3)) u_dut_h (
    .clk(clk), .reset(reset), .tick(tick_h), .clear(1'b0),
    .head_from_l(1'b0), .head_from_u(1'b0), .head_from_r(1'b0), .head_from_d(1'b0),
    .dir(2'b00), .length(8'd7), .apple_place(1'b0),
    .lit(lit_h), .head(head_h), .apple(apple_h), .collision(collision_h), .ate(ate_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lit,head,apple,col,ate}=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, then compare after the edge.
  task automatic step(input string tag, input logic t, input logic clr,
                      input logic [1:0] d, input logic [3:0] nb_lurd,
                      input logic [LEN_W-1:0] len, input logic ap, input logic [4:0] exp);
    tick = t; clear = clr; dir = d; length = len; apple_place = ap;
    {hl, hu, hr, hd} = nb_lurd;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    chk(tag, o, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b0; tick = 0; clear = 0; hl = 0; hu = 0; hr = 0; hd = 0;
    dir = 2'b00; length = '0; apple_place = 0; tick_h = 0;
    #12;
    chk("reset_off", o, 5'b00000);
    chk("reset_init_head", o_h, 5'b11000);
    @(posedge clk); #1;
    reset = 1'b1;

    // Head entry from right with dir=left, length 3
    step("t1_entry",  1, 0, 2'b00, 4'b0010, 8'd3, 0, 5'b11000);
    step("t1_idle",   0, 0, 2'b00, 4'b0000, 8'd3, 0, 5'b11000);
    step("t1_tick1",  1, 0, 2'b00, 4'b0000, 8'd3, 0, 5'b10000);
    step("t1_tick2",  1, 0, 2'b00, 4'b0000, 8'd3, 0, 5'b10000);
    step("t1_tick3",  1, 0, 2'b00, 4'b0000, 8'd3, 0, 5'b00000);

    // Apple placed and eaten
    step("t2_place",  0, 0, 2'b00, 4'b0000, 8'd5, 1, 5'b00100);
    step("t2_hold",   0, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b00100);
    step("t2_tick",   1, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b00100);
    step("t2_eat",    1, 0, 2'b00, 4'b0010, 8'd5, 0, 5'b11001);
    step("t2_ate_1c", 0, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b11000);
    step("t2_c4",     1, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b10000);
    step("t2_c3",     1, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b10000);
    step("t2_c2",     1, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b10000);

    // Collision on body with count 2; sticky until clear
    step("t3_hit",    1, 0, 2'b00, 4'b0010, 8'd5, 0, 5'b10010);
    step("t3_hit2",   1, 0, 2'b00, 4'b0010, 8'd5, 0, 5'b10010);
    step("t3_tick",   1, 0, 2'b00, 4'b0000, 8'd5, 0, 5'b10010);
    step("t3_apple",  0, 0, 2'b00, 4'b0000, 8'd5, 1, 5'b10010);
    step("t3_clear",  0, 1, 2'b00, 4'b0000, 8'd5, 0, 5'b00000);

    // Entry onto the departing tail segment
    step("t4_entry",  1, 0, 2'b00, 4'b0010, 8'd2, 0, 5'b11000);
    step("t4_c1",     1, 0, 2'b00, 4'b0000, 8'd2, 0, 5'b10000);
    step("t4_tail",   1, 0, 2'b00, 4'b0010, 8'd4, 0, 5'b11000);
    step("t4_c3",     1, 0, 2'b00, 4'b0000, 8'd4, 0, 5'b10000);
    step("t4_c2",     1, 0, 2'b00, 4'b0000, 8'd4, 0, 5'b10000);
    step("t4_c1b",    1, 0, 2'b00, 4'b0000, 8'd4, 0, 5'b10000);
    step("t4_off",    1, 0, 2'b00, 4'b0000, 8'd4, 0, 5'b00000);

    // length 0 behaves as 1
    step("len0_entry",1, 0, 2'b00, 4'b0010, 8'd0, 0, 5'b11000);
    step("len0_off",  1, 0, 2'b00, 4'b0000, 8'd0, 0, 5'b00000);

    // Direction selects the neighbour
    step("t5_wrong_r",1, 0, 2'b01, 4'b0010, 8'd3, 0, 5'b00000);
    step("t5_wrong_lu",1,0, 2'b01, 4'b1100, 8'd3, 0, 5'b00000);
    step("t5_right_d",1, 0, 2'b01, 4'b0001, 8'd3, 0, 5'b11000);
    step("t5_notick", 0, 0, 2'b01, 4'b0001, 8'd3, 0, 5'b11000);
    step("t5_clear",  0, 1, 2'b01, 4'b0000, 8'd3, 0, 5'b00000);
    step("dir10_l",   1, 0, 2'b10, 4'b1000, 8'd1, 0, 5'b11000);
    step("dir10_off", 1, 0, 2'b10, 4'b0000, 8'd1, 0, 5'b00000);
    step("dir11_u",   1, 0, 2'b11, 4'b0100, 8'd1, 0, 5'b11000);
    step("dir11_off", 1, 0, 2'b11, 4'b0000, 8'd1, 0, 5'b00000);

    // Priorities: entry beats apple_place, clear beats entry
    step("entry_vs_apple", 1, 0, 2'b01, 4'b0001, 8'd1, 1, 5'b11000);
    step("entry_vs_apple2",1, 0, 2'b01, 4'b0000, 8'd1, 0, 5'b00000);
    step("clear_vs_entry", 1, 1, 2'b01, 4'b0001, 8'd3, 0, 5'b00000);

    // length change mid-countdown has no effect
    step("midlen_entry", 1, 0, 2'b01, 4'b0001, 8'd2, 0, 5'b11000);
    step("midlen_c1",    1, 0, 2'b01, 4'b0000, 8'd9, 0, 5'b10000);
    step("midlen_off",   1, 0, 2'b01, 4'b0000, 8'd9, 0, 5'b00000);

    // Init-head cell: count down, then asynchronous reset mid-countdown
    tick = 0;
    tick_h = 1'b1;
    @(posedge clk); #1;
    tick_h = 1'b0;
    chk("t6_body", o_h, 5'b10000);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_reset", o_h, 5'b11000);
    chk("t6_async_reset_main", o, 5'b00000);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_h = 1'b1;
      @(posedge clk); #1;
      tick_h = 1'b0;
      chk($sformatf("t6_count%0d", i), o_h, (i < 2) ? 5'b10000 : 5'b00000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
